mem_stage_ctrl: RTL and testbench

Memory-stage controller consuming the EX/MEM pipeline register outputs and producing the MEM/WB register contents. Turns load/store flags into a single-outstanding req/ack data-bus transaction. Stalls the upstream pipeline until the transaction completes. Registers ALU results, or load data, toward write-back.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_stage_ctrl_if.sv | 34 +++
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Returned as load data when a bus transaction is abandoned on timeout.
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Signal bundle between EX/MEM, the data bus and MEM/WB for mem_stage_ctrl.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_to_reg;
  logic              mem_write;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] aluResult;
  logic              stall;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              wb_valid;
  logic              mem_to_reg_wb;
  logic [DATA_W-1:0] read_data_wb;
  logic [DATA_W-1:0] aluResult_wb;
  logic              bus_err;

  modport master (
    input  mem_to_reg, mem_write, RD2, aluResult, bus_rdata, bus_ack,
    output stall, bus_req, bus_we, bus_addr, bus_wdata,
    output wb_valid, mem_to_reg_wb, read_data_wb, aluResult_wb, bus_err
  );

  modport slave (
    output mem_to_reg, mem_write, RD2, aluResult, bus_rdata, bus_ack,
    input  stall, bus_req, bus_we, bus_addr, bus_wdata,
    input  wb_valid, mem_to_reg_wb, read_data_wb, aluResult_wb, bus_err
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Purpose: counts cycles spent waiting for a bus ack; expired marks the last allowed cycle.
// Latency: expired is combinational from the count; count advances one per enabled cycle.
// Backpressure: none; clear has priority over enable.
module mem_timeout_ctr #(
  parameter int MAX_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Expired during the MAX_CYC-th enabled cycle, so the abort lands on that cycle's edge.
  assign expired = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: turns EX/MEM load/store flags into one req/ack bus transaction and fills MEM/WB.
// Latency: ALU ops retire 1 cycle after presentation; memory ops retire on the ack edge.
// Backpressure: stall held combinationally from issue until ack; MEM_STAGE_TIMEOUT_EN bounds WAIT.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic clk,
  input  logic rst,
  mem_stage_ctrl_if.master io
);
  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_vld_q, wb_vld_d;
  logic              m2r_wb_q, m2r_wb_d;
  logic [DATA_W-1:0] rdata_wb_q, rdata_wb_d;
  logic [DATA_W-1:0] alu_wb_q, alu_wb_d;
  logic              stall;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic err_q, err_d;
  logic to_clr, to_en, to_expired;

  // Held clear while idle, so every WAIT entry starts from zero.
  assign to_clr = (state_q == IDLE);
  assign to_en  = (state_q == WAIT);

  mem_timeout_ctr #(.MAX_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clr),
    .enable  (to_en),
    .expired (to_expired)
  );
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_vld_d   = 1'b0;
    m2r_wb_d   = m2r_wb_q;
    rdata_wb_d = rdata_wb_q;
    alu_wb_d   = alu_wb_q;
    stall      = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.mem_write || io.mem_to_reg) begin
          stall   = 1'b1;
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = io.mem_write;
          addr_d  = io.aluResult[ADDR_W-1:0];
          wdata_d = io.RD2;
        end else begin
          wb_vld_d = 1'b1;
          alu_wb_d = io.aluResult;
          m2r_wb_d = 1'b0;
        end
      end
      WAIT: begin
        // EX/MEM is frozen by stall, so aluResult still carries this instruction's address.
        stall = 1'b1;
        if (io.bus_ack) begin
          state_d  = RESP;
          req_d    = 1'b0;
          wb_vld_d = 1'b1;
          alu_wb_d = io.aluResult;
          m2r_wb_d = ~we_q;
          if (!we_q) rdata_wb_d = io.bus_rdata;
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        else if (to_expired) begin
          state_d  = RESP;
          req_d    = 1'b0;
          wb_vld_d = 1'b1;
          alu_wb_d = io.aluResult;
          m2r_wb_d = ~we_q;
          if (!we_q) rdata_wb_d = DATA_W'(TIMEOUT_FILL);
          err_d    = 1'b1;
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_vld_q   <= 1'b0;
      m2r_wb_q   <= 1'b0;
      rdata_wb_q <= '0;
      alu_wb_q   <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_vld_q   <= wb_vld_d;
      m2r_wb_q   <= m2r_wb_d;
      rdata_wb_q <= rdata_wb_d;
      alu_wb_q   <= alu_wb_d;
`ifdef MEM_STAGE_TIMEOUT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign io.stall         = stall;
  assign io.bus_req       = req_q;
  assign io.bus_we        = we_q;
  assign io.bus_addr      = addr_q;
  assign io.bus_wdata     = wdata_q;
  assign io.wb_valid      = wb_vld_q;
  assign io.mem_to_reg_wb = m2r_wb_q;
  assign io.read_data_wb  = rdata_wb_q;
  assign io.aluResult_wb  = alu_wb_q;
`ifdef MEM_STAGE_TIMEOUT_EN
  assign io.bus_err       = err_q;
`else
  assign io.bus_err       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: retire scoreboard plus per-cycle bus/stall checks.
// Define MEM_STAGE_TIMEOUT_EN to also exercise the timeout path with TIMEOUT_CYC=4.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int TO = 4;
`endif

  typedef struct {
    logic [31:0] alu;
    logic        m2r;
    logic [31:0] rd;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) io ();

  mem_stage_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  wb_exp_t     sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rd_model = 32'h0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Every retirement must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && io.wb_valid === 1'b1) begin
      check("wb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_alu", io.aluResult_wb, e.alu);
        check("wb_m2r", 32'(io.mem_to_reg_wb), 32'(e.m2r));
        check("wb_rdata", io.read_data_wb, e.rd);
      end
    end
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_req"},   32'(io.bus_req), 32'd0);
    check({pfx, "_we"},    32'(io.bus_we), 32'd0);
    check({pfx, "_addr"},  32'(io.bus_addr), 32'd0);
    check({pfx, "_wdata"}, io.bus_wdata, 32'd0);
    check({pfx, "_wbv"},   32'(io.wb_valid), 32'd0);
    check({pfx, "_m2r"},   32'(io.mem_to_reg_wb), 32'd0);
    check({pfx, "_rdwb"},  io.read_data_wb, 32'd0);
    check({pfx, "_aluwb"}, io.aluResult_wb, 32'd0);
    check({pfx, "_err"},   32'(io.bus_err), 32'd0);
    check({pfx, "_stall"}, 32'(io.stall), 32'd0);
  endtask

  // One idle-state cycle; optional spurious ack must be ignored.
  task automatic alu_op(input logic [31:0] val, input logic ack);
    wb_exp_t e;
    io.mem_to_reg = 1'b0;
    io.mem_write  = 1'b0;
    io.aluResult  = val;
    io.RD2        = 32'h0;
    io.bus_ack    = ack;
    io.bus_rdata  = 32'hFFFF_FFFF;
    e.alu = val; e.m2r = 1'b0; e.rd = rd_model;
    sb.push_back(e);
    @(negedge clk);
    check("alu_stall", 32'(io.stall), 32'd0);
    check("idle_req", 32'(io.bus_req), 32'd0);
    @(posedge clk); #1;
    io.bus_ack = 1'b0;
  endtask

  // Memory op acked in WAIT cycle k; flags stay up through RESP, then an ALU op follows.
  task automatic mem_op(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wd, input int k, input logic [31:0] rdat);
    int      stalls = 0;
    logic    is_load;
    wb_exp_t e;
    is_load       = ld & ~st;
    io.mem_to_reg = ld;
    io.mem_write  = st;
    io.aluResult  = addr;
    io.RD2        = wd;
    io.bus_ack    = 1'b0;
    io.bus_rdata  = 32'h0;
    if (is_load) rd_model = rdat;
    e.alu = addr; e.m2r = is_load; e.rd = rd_model;
    sb.push_back(e);
    @(negedge clk);
    if (io.stall) stalls++;
    @(posedge clk); #1;
    for (int i = 1; i <= k; i++) begin
      if (i == k) begin
        io.bus_ack   = 1'b1;
        io.bus_rdata = rdat;
      end
      @(negedge clk);
      if (io.stall) stalls++;
      check("wait_req", 32'(io.bus_req), 32'd1);
      check("wait_we", 32'(io.bus_we), 32'(st));
      check("wait_addr", 32'(io.bus_addr), {16'h0, addr[15:0]});
      check("wait_wdata", io.bus_wdata, wd);
      @(posedge clk); #1;
    end
    io.bus_ack = 1'b0;
    @(negedge clk);
    if (io.stall) stalls++;
    check("resp_req", 32'(io.bus_req), 32'd0);
    check("stall_cycles", 32'(stalls), 32'(k + 1));
    @(posedge clk); #1;
    alu_op(32'h0000_0000, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    io.mem_to_reg = 1'b0;
    io.mem_write  = 1'b0;
    io.RD2        = 32'h0;
    io.aluResult  = 32'h0;
    io.bus_rdata  = 32'h0;
    io.bus_ack    = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    alu_op(32'h0000_1234, 1'b0);
    alu_op(32'hA5A5_0001, 1'b0);
    mem_op(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3, 32'h7777_7777);
    mem_op(1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 1, 32'h1111_2222);
    mem_op(1'b1, 1'b1, 32'h0000_00C4, 32'h0BAD_CAFE, 2, 32'h3333_4444);
    mem_op(1'b1, 1'b0, 32'h0001_FFFC, 32'h0000_0000, 5, 32'h5555_6666);
    alu_op(32'hFFFF_FFFF, 1'b1);

    // Reset while a load waits for its ack: nothing retires, everything clears.
    io.mem_to_reg = 1'b1;
    io.aluResult  = 32'h0000_0200;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(io.bus_req), 32'd1);
    @(posedge clk); #1;
    rst           = 1'b1;
    io.mem_to_reg = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset("rst_wait");
    rd_model = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;

    mem_op(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 2, 32'h9999_AAAA);

`ifdef MEM_STAGE_TIMEOUT_EN
    begin : timeout_test
      int      n;
      bit      done;
      wb_exp_t e;
      n    = 0;
      done = 1'b0;
      rd_model = TIMEOUT_FILL;
      e.alu = 32'h0000_0100; e.m2r = 1'b1; e.rd = TIMEOUT_FILL;
      sb.push_back(e);
      io.mem_to_reg = 1'b1;
      io.mem_write  = 1'b0;
      io.aluResult  = 32'h0000_0100;
      @(negedge clk);
      @(posedge clk); #1;
      for (int i = 0; i < 12 && !done; i++) begin
        @(negedge clk);
        if (io.bus_req) n++;
        else done = 1'b1;
        if (!done) begin
          @(posedge clk); #1;
        end
      end
      check("to_wait_cycles", 32'(n), 32'(TO));
      check("to_err_set", 32'(io.bus_err), 32'd1);
      @(posedge clk); #1;
      alu_op(32'h0000_0042, 1'b0);
      check("to_err_sticky", 32'(io.bus_err), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("to_err_cleared", 32'(io.bus_err), 32'd0);
      rst      = 1'b0;
      rd_model = 32'h0;
    end
`else
    check("bus_err_off", 32'(io.bus_err), 32'd0);
`endif

    alu_op(32'h0000_5678, 1'b0);
    @(negedge clk); #2;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
